// File: rtl/viterbi_pkg.sv
// Shared types and sizing helpers for the parametrised Viterbi traceback unit.
package viterbi_pkg;

    localparam int K_MIN = 3;
    localparam int K_MAX = 9;

    typedef enum logic [1:0] {
        WARM  = 2'd0,
        READY = 2'd1,
        TRACE = 2'd2
    } tbu_state_t;

    function automatic int num_states(input int k);
        return int'(32'd1 << (k - 1));
    endfunction

    function automatic int state_width(input int k);
        return k - 1;
    endfunction

endpackage

// File: rtl/viterbi_tbu_argmin.sv
// Combinational NS-way unsigned minimum-index tree; on a tie the lower state index wins.
module viterbi_tbu_argmin #(
    parameter int NS       = 4,
    parameter int SW       = 2,
    parameter int PM_WIDTH = 8
) (
    input  logic [NS*PM_WIDTH-1:0] i_pm,
    output logic [SW-1:0]          o_idx
);

    logic [PM_WIDTH-1:0] w_val [SW+1][NS];
    logic [SW-1:0]       w_idx [SW+1][NS];

    // Pairwise reduction, one level per state bit; the left (lower-index) node keeps ties
    always_comb begin
        for (int l = 0; l <= SW; l++) begin
            for (int n = 0; n < NS; n++) begin
                w_val[l][n] = '0;
                w_idx[l][n] = '0;
            end
        end
        for (int n = 0; n < NS; n++) begin
            w_val[0][n] = i_pm[n*PM_WIDTH +: PM_WIDTH];
            w_idx[0][n] = SW'(n);
        end
        for (int l = 1; l <= SW; l++) begin
            for (int n = 0; n < (NS >> l); n++) begin
                if (w_val[l-1][2*n+1] < w_val[l-1][2*n]) begin
                    w_val[l][n] = w_val[l-1][2*n+1];
                    w_idx[l][n] = w_idx[l-1][2*n+1];
                end else begin
                    w_val[l][n] = w_val[l-1][2*n];
                    w_idx[l][n] = w_idx[l-1][2*n];
                end
            end
        end
        o_idx = w_idx[SW][0];
    end

endmodule

// File: rtl/viterbi_tbu_gen.sv
// Generic-K Viterbi traceback unit: survivor ring buffer, argmin start-state search
// and a serial traceback that emits one decoded bit per accepted stage.
module viterbi_tbu_gen
    import viterbi_pkg::*;
#(
    parameter int K          = 3,
    parameter int TBL        = 15,
    parameter int PM_WIDTH   = 8,
    parameter bit ZERO_START = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_i,
    input  logic [num_states(K)-1:0]          dec_i,
    input  logic [num_states(K)*PM_WIDTH-1:0] pm_i,
    output logic                             busy_o,
    output logic                             data_serial_o,
    output logic                             valid_serial_o,
    output logic                             overflow_o
);

    localparam int NS = num_states(K);
    localparam int SW = state_width(K);
    localparam int AW = (TBL > 1) ? $clog2(TBL) : 1;
    localparam int CW = $clog2(TBL + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(TBL - 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(TBL - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TBL);

    if ((K < K_MIN) || (K > K_MAX) || (TBL < 2)) begin : g_param_check
        $error("viterbi_tbu_gen: K must be in 3..9 and TBL at least 2");
    end

    tbu_state_t       r_fsm;
    tbu_state_t       w_fsm_nxt;
    logic [NS-1:0]    r_mem [TBL];
    logic [NS-1:0]    r_rd_word;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_fill;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_tb_state;
    logic [SW-1:0]    w_tb_start;
    logic [SW-1:0]    w_tb_nxt;
    logic [SW-1:0]    w_argmin_idx;
    logic             w_accept;
    logic             w_trigger;
    logic             w_warm_done;
    logic             w_tracing;
    logic             w_step;
    logic             w_final;
    logic             w_dec_bit;
    logic             w_out_bit;
    logic             r_busy;
    logic             r_valid_serial;
    logic             r_data_serial;
    logic             r_overflow;

    viterbi_tbu_argmin #(
        .NS       (NS),
        .SW       (SW),
        .PM_WIDTH (PM_WIDTH)
    ) u_argmin (
        .i_pm  (pm_i),
        .o_idx (w_argmin_idx)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= WARM;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            WARM:    w_fsm_nxt = w_warm_done ? READY : WARM;
            READY:   w_fsm_nxt = w_trigger ? TRACE : READY;
            TRACE:   w_fsm_nxt = w_final ? READY : TRACE;
            default: w_fsm_nxt = WARM;
        endcase
    end

    // FSM output decode plus one traceback step on the registered survivor word
    always_comb begin
        w_accept    = valid_i & ~r_busy;
        w_tracing   = (r_fsm == TRACE);
        w_warm_done = w_accept & (r_fsm == WARM) & (r_fill == FILL_LAST);
        w_trigger   = w_accept & (r_fsm == READY);
        w_step      = w_tracing & (r_cnt != '0);
        w_final     = w_tracing & (r_cnt == CNT_LAST);
        w_dec_bit   = r_rd_word[r_tb_state];
        w_out_bit   = r_tb_state[SW-1];
        w_tb_nxt    = {r_tb_state[SW-2:0], w_dec_bit};
        if (ZERO_START) begin
            w_tb_start = '0;
        end else begin
            w_tb_start = w_argmin_idx;
        end
    end

    // Survivor RAM: write on accept, registered read while tracing (contents never reset)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= dec_i;
        end
        if (w_tracing) begin
            r_rd_word <= r_mem[r_rd_ptr];
        end
    end

    // Fill count, ring pointers and traceback cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_accept && (r_fsm == WARM)) begin
                r_fill <= r_fill + CW'(1);
            end
            if (w_accept) begin
                r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + AW'(1);
            end
            // The first read targets the slot being written on the trigger edge
            if (w_trigger) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_tracing) begin
                r_rd_ptr <= (r_rd_ptr == '0) ? LAST_ADDR : r_rd_ptr - AW'(1);
            end
            if (w_trigger) begin
                r_cnt <= '0;
            end else if (w_tracing) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Traceback state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tb_state     <= '0;
            r_busy         <= 1'b0;
            r_valid_serial <= 1'b0;
            r_data_serial  <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_trigger) begin
                r_tb_state <= w_tb_start;
            end else if (w_step) begin
                r_tb_state <= w_tb_nxt;
            end
            if (w_trigger) begin
                r_busy <= 1'b1;
            end else if (w_final) begin
                r_busy <= 1'b0;
            end
            r_valid_serial <= w_final;
            if (w_final) begin
                r_data_serial <= w_out_bit;
            end
            if (valid_i && r_busy) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign busy_o         = r_busy;
    assign data_serial_o  = r_data_serial;
    assign valid_serial_o = r_valid_serial;
    assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_viterbi_tbu_gen.sv
// Directed bench for viterbi_tbu_gen: two K=3 instances (argmin / zero-start) and one K=5 instance.
module tb_viterbi_tbu_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         a_valid;
    logic [3:0]   a_dec;
    logic [31:0]  a_pm;
    logic         a_busy, a_data, a_vso, a_ovf;
    logic         b_busy, b_data, b_vso, b_ovf;
    logic         c_valid;
    logic [15:0]  c_dec;
    logic [127:0] c_pm;
    logic         c_busy, c_data, c_vso, c_ovf;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] u_seq = 64'hC3A5_5A3C_E18F_2D69;

    viterbi_tbu_gen #(.K(3), .TBL(15), .PM_WIDTH(8), .ZERO_START(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .valid_i(a_valid), .dec_i(a_dec), .pm_i(a_pm),
        .busy_o(a_busy), .data_serial_o(a_data), .valid_serial_o(a_vso), .overflow_o(a_ovf)
    );

    viterbi_tbu_gen #(.K(3), .TBL(15), .PM_WIDTH(8), .ZERO_START(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .valid_i(a_valid), .dec_i(a_dec), .pm_i(a_pm),
        .busy_o(b_busy), .data_serial_o(b_data), .valid_serial_o(b_vso), .overflow_o(b_ovf)
    );

    viterbi_tbu_gen #(.K(5), .TBL(20), .PM_WIDTH(8), .ZERO_START(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .valid_i(c_valid), .dec_i(c_dec), .pm_i(c_pm),
        .busy_o(c_busy), .data_serial_o(c_data), .valid_serial_o(c_vso), .overflow_o(c_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] pm4(input logic [7:0] p0, input logic [7:0] p1,
                                        input logic [7:0] p2, input logic [7:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    // Decision word of stage n for an encoder driven by u_seq: every state's survivor drops u[n-2]
    function automatic logic [3:0] seq_word(input int n);
        logic b;
        if (n < 2) return 4'b0000;
        b = u_seq[n-2];
        return {4{b}};
    endfunction

    function automatic logic seq_bit(input int n);
        return u_seq[n];
    endfunction

    task automatic apply_reset();
        a_valid = 1'b0;
        c_valid = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic warm_a(input logic [3:0] d);
        for (int i = 0; i < 15; i++) begin
            a_valid = 1'b1;
            a_dec   = d;
            @(negedge clk);
        end
        a_valid = 1'b0;
    endtask

    task automatic warm_seq();
        for (int n = 0; n < 15; n++) begin
            a_valid = 1'b1;
            a_dec   = seq_word(n);
            @(negedge clk);
        end
        a_valid = 1'b0;
    endtask

    task automatic wait_strobe_a(input int k0, output int k);
        k = k0;
        do begin
            @(negedge clk);
            k++;
        end while (a_vso !== 1'b1 && k < 60);
    endtask

    task automatic run_a(input string tag, input logic [3:0] d, input logic [31:0] pm,
                         input logic exp_a, input logic exp_b);
        int k;
        a_valid = 1'b1;
        a_dec   = d;
        a_pm    = pm;
        @(negedge clk);
        a_valid = 1'b0;
        check_eq({tag, "_busy_a"}, 32'(a_busy), 32'd1);
        check_eq({tag, "_busy_b"}, 32'(b_busy), 32'd1);
        wait_strobe_a(0, k);
        check_eq({tag, "_latency"}, 32'(k), 32'd16);
        check_eq({tag, "_vso_b"}, 32'(b_vso), 32'd1);
        check_eq({tag, "_data_a"}, 32'(a_data), 32'(exp_a));
        check_eq({tag, "_data_b"}, 32'(b_data), 32'(exp_b));
        check_eq({tag, "_busy_end"}, 32'(a_busy), 32'd0);
        @(negedge clk);
        check_eq({tag, "_vso_pulse"}, 32'(a_vso), 32'd0);
    endtask

    initial begin
        int k;
        int strobes;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        a_dec   = 4'd0;
        a_pm    = 32'd0;
        c_valid = 1'b0;
        c_dec   = 16'd0;
        c_pm    = 128'd0;

        apply_reset();
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_data", 32'(a_data), 32'd0);
        check_eq("rst_vso", 32'(a_vso), 32'd0);
        check_eq("rst_ovf", 32'(a_ovf), 32'd0);
        check_eq("rst_busy_c", 32'(c_busy), 32'd0);

        // All-zero survivors, state 0 best
        warm_a(4'b0000);
        check_eq("warm_no_trig", 32'(a_busy), 32'd0);
        check_eq("warm_no_vso", 32'(a_vso), 32'd0);
        run_a("zeros", 4'b0000, pm4(8'd0, 8'd255, 8'd255, 8'd255), 1'b0, 1'b0);

        // All-one survivors: state 3 is a fixed point, zero-start also converges to 3
        apply_reset();
        warm_a(4'b1111);
        run_a("ones_s3", 4'b1111, pm4(8'd255, 8'd255, 8'd255, 8'd0), 1'b1, 1'b1);
        run_a("ones_s1", 4'b1111, pm4(8'd255, 8'd0, 8'd0, 8'd0), 1'b1, 1'b1);

        // Survivors 1100 swap states 1<->2 and keep 0/3, so output = MSB of the start state
        apply_reset();
        warm_a(4'b1100);
        run_a("tie_all7", 4'b1100, {4{8'd7}}, 1'b0, 1'b0);
        run_a("tie_1_2", 4'b1100, pm4(8'd9, 8'd7, 8'd7, 8'd9), 1'b0, 1'b0);
        run_a("min_s2", 4'b1100, pm4(8'd255, 8'd255, 8'd0, 8'd255), 1'b1, 1'b0);
        run_a("unsigned", 4'b1100, pm4(8'd200, 8'd128, 8'd100, 8'd90), 1'b1, 1'b0);

        // Overflow: a sample offered at E5 of a traceback is dropped
        apply_reset();
        check_eq("ovf_pre", 32'(a_ovf), 32'd0);
        warm_seq();
        check_eq("ovf_warm", 32'(a_ovf), 32'd0);
        a_valid = 1'b1;
        a_dec   = seq_word(15);
        a_pm    = 32'd0;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        a_valid = 1'b1;
        a_dec   = 4'b0110;
        @(negedge clk);
        a_valid = 1'b0;
        check_eq("ovf_set_a", 32'(a_ovf), 32'd1);
        check_eq("ovf_set_b", 32'(b_ovf), 32'd1);
        wait_strobe_a(5, k);
        check_eq("ovf_latency", 32'(k), 32'd16);
        check_eq("ovf_data", 32'(a_data), 32'(seq_bit(1)));
        for (int n = 16; n < 19; n++) begin
            run_a("ovf_next", seq_word(n), 32'd0, seq_bit(n - 14), seq_bit(n - 14));
        end
        check_eq("ovf_sticky", 32'(a_ovf), 32'd1);

        // valid_i held high: one output every 17 cycles reproducing u_seq
        apply_reset();
        for (int n = 0; n < 15; n++) begin
            a_valid = 1'b1;
            a_dec   = seq_word(n);
            @(negedge clk);
        end
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < 17; c++) begin
                a_valid = 1'b1;
                a_dec   = (c == 0) ? seq_word(15 + t) : 4'b0110;
                @(negedge clk);
                if (c == 16) begin
                    check_eq("cont_vso", 32'(a_vso), 32'd1);
                    check_eq("cont_data", 32'(a_data), 32'(seq_bit(t + 1)));
                    check_eq("cont_busy", 32'(a_busy), 32'd0);
                end
            end
        end
        a_valid = 1'b0;
        check_eq("cont_ovf", 32'(a_ovf), 32'd1);

        // K=5, TBL=20: reset mid-traceback abandons it and restarts warm-up
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            c_valid = 1'b1;
            c_dec   = 16'hFFFF;
            @(negedge clk);
        end
        c_valid = 1'b0;
        check_eq("c_warm_no_trig", 32'(c_busy), 32'd0);
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        check_eq("c_busy", 32'(c_busy), 32'd1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("c_rst_busy", 32'(c_busy), 32'd0);
        strobes = 0;
        repeat (3) begin
            @(negedge clk);
            strobes += int'(c_vso);
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            strobes += int'(c_vso);
        end
        check_eq("c_abandon", 32'(strobes), 32'd0);
        check_eq("c_ovf_clr", 32'(c_ovf), 32'd0);
        for (int i = 0; i < 20; i++) begin
            c_valid = 1'b1;
            c_dec   = 16'hFFFF;
            @(negedge clk);
            strobes += int'(c_vso);
        end
        c_valid = 1'b0;
        check_eq("c_rewarm_busy", 32'(c_busy), 32'd0);
        check_eq("c_rewarm_vso", 32'(strobes), 32'd0);
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        check_eq("c_trig21", 32'(c_busy), 32'd1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (c_vso !== 1'b1 && k < 60);
        check_eq("c_latency", 32'(k), 32'd21);
        check_eq("c_data", 32'(c_data), 32'd1);
        check_eq("c_busy_end", 32'(c_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
